memory_stage: RTL

Pipeline MEM stage, directly downstream of the execute stage. Latches the EX/MEM pipeline register and drives single-word read or write requests to the data cache. Stalls the pipeline until the cache returns `dhit`, selects the writeback value and registers the MEM/WB pipeline register for the writeback stage. It also exports MEM-stage forwarding information.

---
 rtl/memory_stage_if.sv | 63 ++++++
 rtl/memory_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// memory_stage_if: bundle of every non-clock/reset signal of the MEM pipeline stage.
//   EX inputs    : memen, flush, nPC, ALUOut, dmemstore, lui, dREN, dWEN, regWr, halt,
//                  regSel, regDst
//   Cache side   : dmemREN, dmemWEN, dmemaddr, dmemstore_out (out), dhit, dmemload (in)
//   Status       : mem_stall
//   Forwarding   : fwd_regWr, fwd_regDst, fwd_data, fwd_isload
//   MEM/WB       : wb_regWr, wb_regDst, wb_wdat, wb_halt
//   MEM_LLSC_EN  : datomic, ccinv, ccinvaddr (only present when the macro is defined)
// Modports: master = the MEM stage itself, slave = its environment (EX, cache, hazard, WB).
interface memory_stage_if;
   logic        memen;
   logic        flush;
   logic [31:0] nPC;
   logic [31:0] ALUOut;
   logic [31:0] dmemstore;
   logic [31:0] lui;
   logic        dREN;
   logic        dWEN;
   logic        regWr;
   logic        halt;
   logic [1:0]  regSel;
   logic [4:0]  regDst;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore_out;
   logic        dhit;
   logic [31:0] dmemload;
   logic        mem_stall;
   logic        fwd_regWr;
   logic [4:0]  fwd_regDst;
   logic [31:0] fwd_data;
   logic        fwd_isload;
   logic        wb_regWr;
   logic [4:0]  wb_regDst;
   logic [31:0] wb_wdat;
   logic        wb_halt;
`ifdef MEM_LLSC_EN
   logic        datomic;
   logic        ccinv;
   logic [31:0] ccinvaddr;
`endif

   modport master (
      input  memen, flush, nPC, ALUOut, dmemstore, lui, dREN, dWEN, regWr, halt, regSel,
             regDst, dhit, dmemload,
`ifdef MEM_LLSC_EN
      input  datomic, ccinv, ccinvaddr,
`endif
      output dmemREN, dmemWEN, dmemaddr, dmemstore_out, mem_stall, fwd_regWr, fwd_regDst,
             fwd_data, fwd_isload, wb_regWr, wb_regDst, wb_wdat, wb_halt
   );

   modport slave (
      output memen, flush, nPC, ALUOut, dmemstore, lui, dREN, dWEN, regWr, halt, regSel,
             regDst, dhit, dmemload,
`ifdef MEM_LLSC_EN
      output datomic, ccinv, ccinvaddr,
`endif
      input  dmemREN, dmemWEN, dmemaddr, dmemstore_out, mem_stall, fwd_regWr, fwd_regDst,
             fwd_data, fwd_isload, wb_regWr, wb_regDst, wb_wdat, wb_halt
   );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage. Holds the EX/MEM register, issues one data-cache access
// per instruction, stalls until dhit, selects the writeback value and registers MEM/WB.
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - memory_stage_if.master (EX inputs, cache request/response, forwarding, MEM/WB)
// Optional feature: define MEM_LLSC_EN to add load-linked / store-conditional support
// (datomic, ccinv, ccinvaddr plus a link register with a valid bit).
module memory_stage (
   input logic            CLK,
   input logic            nRST,
   memory_stage_if.master bus
);

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] aluout;
      logic [31:0] store;
      logic [31:0] lui;
      logic        dren;
      logic        dwen;
      logic        regwr;
      logic        halt;
      logic [1:0]  regsel;
      logic [4:0]  regdst;
`ifdef MEM_LLSC_EN
      logic        datomic;
`endif
   } ex_mem_t;

   ex_mem_t     r_m;
   ex_mem_t     w_m_in;
   logic        r_done;
   logic [31:0] r_ldata;
   logic        r_wb_regwr;
   logic [4:0]  r_wb_regdst;
   logic [31:0] r_wb_wdat;
   logic        r_wb_halt;

   logic        w_ren;
   logic        w_wen;
   logic        w_stall;
   logic        w_advance;
   logic        w_load_m;
   logic        w_sc_fail;
   logic [31:0] w_ld_val;
   logic [31:0] w_sel;

   always_comb begin
      w_m_in        = '0;
      w_m_in.npc    = bus.nPC;
      w_m_in.aluout = bus.ALUOut;
      w_m_in.store  = bus.dmemstore;
      w_m_in.lui    = bus.lui;
      // A simultaneous read and write request resolves to the write.
      w_m_in.dren   = bus.dREN & ~bus.dWEN;
      w_m_in.dwen   = bus.dWEN;
      w_m_in.regwr  = bus.regWr;
      w_m_in.halt   = bus.halt;
      w_m_in.regsel = bus.regSel;
      w_m_in.regdst = bus.regDst;
`ifdef MEM_LLSC_EN
      w_m_in.datomic = bus.datomic;
`endif
   end

`ifdef MEM_LLSC_EN
   logic [31:0] r_link;
   logic        r_link_valid;
   logic        w_link_ok;
   logic        w_is_sc;

   assign w_is_sc   = r_m.datomic & r_m.dwen;
   assign w_link_ok = r_link_valid & (r_link == r_m.aluout);
   assign w_sc_fail = w_is_sc & ~w_link_ok;

   // Later assignments win: an LL completing in the same cycle re-arms the link.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_link       <= '0;
         r_link_valid <= 1'b0;
      end else begin
         if (bus.ccinv && (bus.ccinvaddr == r_link)) r_link_valid <= 1'b0;
         if (w_wen && bus.dhit && (r_m.datomic || (r_m.aluout == r_link))) begin
            r_link_valid <= 1'b0;
         end
         // Covers a failed SC, which never reaches the cache.
         if (w_advance && w_is_sc) r_link_valid <= 1'b0;
         if (w_ren && bus.dhit && r_m.datomic) begin
            r_link       <= r_m.aluout;
            r_link_valid <= 1'b1;
         end
      end
   end
`else
   assign w_sc_fail = 1'b0;
`endif

   assign w_ren     = r_m.dren & ~r_done;
   assign w_wen     = r_m.dwen & ~r_done & ~w_sc_fail;
   assign w_stall   = (w_ren | w_wen) & ~bus.dhit;
   assign w_advance = bus.memen & ~w_stall;
   assign w_load_m  = bus.flush | w_advance;
   // On the dhit cycle the captured copy is not yet written, so bypass it.
   assign w_ld_val  = r_done ? r_ldata : bus.dmemload;

   always_comb begin
      w_sel = r_m.aluout;
      unique case (r_m.regsel)
         2'd0: w_sel = r_m.aluout;
         2'd1: w_sel = w_ld_val;
         2'd2: w_sel = r_m.npc;
         2'd3: w_sel = r_m.lui;
      endcase
`ifdef MEM_LLSC_EN
      // Once done is set the SC write has completed, so it succeeded.
      if (w_is_sc) w_sel = {31'b0, r_done | w_link_ok};
`endif
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_m <= '0;
      end else if (bus.flush) begin
         r_m <= '0;
      end else if (w_advance) begin
         r_m <= w_m_in;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_done <= 1'b0;
      end else if (w_load_m) begin
         r_done <= 1'b0;
      end else if ((w_ren | w_wen) & bus.dhit) begin
         r_done <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ldata <= '0;
      end else if (w_ren & bus.dhit) begin
         r_ldata <= bus.dmemload;
      end
   end

   // MEM/WB takes the instruction only on the cycle it leaves M, else a bubble.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_wb_regwr  <= 1'b0;
         r_wb_regdst <= '0;
         r_wb_wdat   <= '0;
         r_wb_halt   <= 1'b0;
      end else if (w_advance) begin
         r_wb_regwr  <= r_m.regwr;
         r_wb_regdst <= r_m.regdst;
         r_wb_wdat   <= w_sel;
         r_wb_halt   <= r_wb_halt | r_m.halt;
      end else begin
         r_wb_regwr  <= 1'b0;
         r_wb_regdst <= '0;
         r_wb_wdat   <= '0;
      end
   end

   assign bus.dmemREN       = w_ren;
   assign bus.dmemWEN       = w_wen;
   assign bus.dmemaddr      = r_m.aluout;
   assign bus.dmemstore_out = r_m.store;
   assign bus.mem_stall     = w_stall;
   assign bus.fwd_regWr     = r_m.regwr;
   assign bus.fwd_regDst    = r_m.regdst;
   assign bus.fwd_data      = w_sel;
   assign bus.fwd_isload    = r_m.dren;
   assign bus.wb_regWr      = r_wb_regwr;
   assign bus.wb_regDst     = r_wb_regdst;
   assign bus.wb_wdat       = r_wb_wdat;
   assign bus.wb_halt       = r_wb_halt;

endmodule
